// File: rtl/hazard_if.sv
// Hazard unit port bundle: pipeline register/control view in, forwarding, stall
// and flush controls plus performance counters out.
interface hazard_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
    logic [4:0]       RdE, RdM, RdW;
    logic             PCSrcE;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW;
    logic             MemReqM, MemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount, FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               PCSrcE, ResultSrcE, RegWriteM, RegWriteW,
               MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE,
               StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW,
               MemTimeout, StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               PCSrcE, ResultSrcE, RegWriteM, RegWriteW,
               MemReqM, MemReadyM,
        output ForwardAE, ForwardBE,
               StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW,
               MemTimeout, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and
// data-memory wait handling with timeout FSM and saturating event counters.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic  clk,
    input logic  reset,
    hazard_if.slave hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic             mto_q;
    logic [CNT_W-1:0] scnt_q, fcnt_q;

    logic lw_stall, mem_stall, run_like;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign run_like  = (state_q == S_RUN) || (state_q == S_WAIT);
    assign mem_stall = run_like && hz.MemReqM && !hz.MemReadyM;
    assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0)
                     && ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE))
                     && !hz.PCSrcE;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        fwd_a   = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM,
                          hz.RegWriteW, hz.RdW);
        fwd_b   = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM,
                          hz.RegWriteW, hz.RdW);
        // A memory stall holds everything, including a resolved branch in E
        if (!run_like || mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = lw_stall;
            stall_d = lw_stall;
            flush_d = hz.PCSrcE;
            flush_e = lw_stall | hz.PCSrcE;
        end
        if (reset) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
            flush_w = 1'b0;
            fwd_a   = 2'b00;
            fwd_b   = 2'b00;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_RUN: begin
                wcnt_d = '0;
                if (mem_stall) state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + WCW'(1);
                if (hz.MemReadyM)
                    state_d = S_RUN;
                else if (32'(wcnt_q) + 32'd1 >= 32'(MEM_TIMEOUT))
                    state_d = S_ERR;
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            wcnt_q  <= '0;
            mto_q   <= 1'b0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_d == S_ERR) mto_q <= 1'b1;
            if (state_q != S_ERR) begin
                if (stall_f && scnt_q != '1)
                    scnt_q <= scnt_q + CNT_W'(1);
                if ((flush_d || flush_e) && fcnt_q != '1)
                    fcnt_q <= fcnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.ForwardAE  = fwd_a;
    assign hz.ForwardBE  = fwd_b;
    assign hz.StallF     = stall_f;
    assign hz.StallD     = stall_d;
    assign hz.StallE     = stall_e;
    assign hz.StallM     = stall_m;
    assign hz.FlushD     = flush_d;
    assign hz.FlushE     = flush_e;
    assign hz.FlushW     = flush_w;
    assign hz.MemTimeout = mto_q;
    assign hz.StallCount = scnt_q;
    assign hz.FlushCount = fcnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with MEM_TIMEOUT=4 and 4-bit counters.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   pass_cnt = 0;
    int   tot_cnt = 0;

    hazard_if #(.CNT_W(4)) hif ();

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    always #5 clk = ~clk;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [6:0] ctl();
        return {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                hif.FlushD, hif.FlushE, hif.FlushW};
    endfunction

    task automatic idle();
        hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
        hif.PCSrcE = 0; hif.ResultSrcE = 0;
        hif.RegWriteM = 0; hif.RegWriteW = 0;
        hif.MemReqM = 0; hif.MemReadyM = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        hif.PCSrcE = 1; hif.MemReqM = 1;
        hif.RegWriteM = 1; hif.RdM = 5; hif.Rs1E = 5;
        reset = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if (ctl() !== 7'b0) $display("FAIL reset_ctl got %b exp %b", ctl(), 7'b0);
        else pass_cnt++;
        tot_cnt++;
        if (hif.ForwardAE !== 2'b00) $display("FAIL reset_fwd got %b exp 00", hif.ForwardAE);
        else pass_cnt++;
        tot_cnt++;
        if (hif.StallCount !== 4'd0 || hif.FlushCount !== 4'd0 || hif.MemTimeout !== 1'b0)
            $display("FAIL reset_regs got %0d %0d %b exp 0 0 0",
                     hif.StallCount, hif.FlushCount, hif.MemTimeout);
        else pass_cnt++;
        idle();
        reset = 1'b0;
    endtask

    task automatic test_forward();
        do_reset();
        @(negedge clk);
        hif.RegWriteM = 1; hif.RdM = 5; hif.RegWriteW = 1; hif.RdW = 5;
        hif.Rs1E = 5; hif.Rs2E = 5;
        #1;
        tot_cnt++;
        if (hif.ForwardAE !== 2'b10) $display("FAIL fwdA_mem got %b exp 10", hif.ForwardAE);
        else pass_cnt++;
        tot_cnt++;
        if (hif.ForwardBE !== 2'b10) $display("FAIL fwdB_mem got %b exp 10", hif.ForwardBE);
        else pass_cnt++;
        hif.RegWriteM = 0;
        #1;
        tot_cnt++;
        if (hif.ForwardAE !== 2'b01) $display("FAIL fwdA_wb got %b exp 01", hif.ForwardAE);
        else pass_cnt++;
        hif.RegWriteM = 1; hif.RdM = 7; hif.Rs1E = 7; hif.Rs2E = 3;
        #1;
        tot_cnt++;
        if (hif.ForwardAE !== 2'b10 || hif.ForwardBE !== 2'b00)
            $display("FAIL fwd_split got %b/%b exp 10/00", hif.ForwardAE, hif.ForwardBE);
        else pass_cnt++;
        hif.RdM = 0; hif.RdW = 0; hif.Rs1E = 0; hif.Rs2E = 0;
        #1;
        tot_cnt++;
        if (hif.ForwardAE !== 2'b00 || hif.ForwardBE !== 2'b00)
            $display("FAIL fwd_x0 got %b/%b exp 00/00", hif.ForwardAE, hif.ForwardBE);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        hif.ResultSrcE = 2'b01; hif.RdE = 6; hif.Rs2D = 6;
        #1;
        tot_cnt++;
        if (ctl() !== 7'b1100010) $display("FAIL lw_ctl got %b exp %b", ctl(), 7'b1100010);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        tot_cnt++;
        if (hif.StallCount !== 4'd1 || hif.FlushCount !== 4'd1)
            $display("FAIL lw_cnt got %0d/%0d exp 1/1", hif.StallCount, hif.FlushCount);
        else pass_cnt++;
        hif.ResultSrcE = 2'b01; hif.RdE = 0; hif.Rs1D = 0;
        #1;
        tot_cnt++;
        if (ctl() !== 7'b0) $display("FAIL lw_x0 got %b exp %b", ctl(), 7'b0);
        else pass_cnt++;
        hif.RdE = 9; hif.Rs1D = 9; hif.PCSrcE = 1;
        #1;
        tot_cnt++;
        if (ctl() !== 7'b0000110) $display("FAIL lw_branch got %b exp %b", ctl(), 7'b0000110);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        hif.PCSrcE = 1;
        #1;
        tot_cnt++;
        if (ctl() !== 7'b0000110) $display("FAIL br_ctl got %b exp %b", ctl(), 7'b0000110);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        tot_cnt++;
        if (hif.FlushCount !== 4'd1 || hif.StallCount !== 4'd0)
            $display("FAIL br_cnt got %0d/%0d exp 1/0", hif.FlushCount, hif.StallCount);
        else pass_cnt++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            hif.MemReqM = 1; hif.MemReadyM = 0; hif.PCSrcE = 1;
            #1;
            tot_cnt++;
            if (ctl() !== 7'b1111001)
                $display("FAIL memwait_ctl%0d got %b exp %b", i, ctl(), 7'b1111001);
            else pass_cnt++;
        end
        @(negedge clk);
        hif.MemReadyM = 1;
        #1;
        tot_cnt++;
        if (ctl() !== 7'b0000110) $display("FAIL memwait_rel got %b exp %b", ctl(), 7'b0000110);
        else pass_cnt++;
        @(negedge clk);
        idle();
        #1;
        tot_cnt++;
        if (hif.StallCount !== 4'd3 || hif.FlushCount !== 4'd1 || hif.MemTimeout !== 1'b0)
            $display("FAIL memwait_cnt got %0d/%0d/%b exp 3/1/0",
                     hif.StallCount, hif.FlushCount, hif.MemTimeout);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hif.MemReqM = 1; hif.MemReadyM = 0;
            #1;
            if (i == 4) begin
                tot_cnt++;
                if (hif.MemTimeout !== 1'b0)
                    $display("FAIL to_early got %b exp 0", hif.MemTimeout);
                else pass_cnt++;
            end
        end
        @(negedge clk);
        hif.MemReqM = 0; hif.PCSrcE = 1;
        #1;
        tot_cnt++;
        if (hif.MemTimeout !== 1'b1 || ctl() !== 7'b1111001)
            $display("FAIL to_err got %b/%b exp 1/%b", hif.MemTimeout, ctl(), 7'b1111001);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        #1;
        tot_cnt++;
        if (hif.MemTimeout !== 1'b1 || hif.StallCount !== 4'd5 || hif.FlushCount !== 4'd0)
            $display("FAIL to_sticky got %b/%0d/%0d exp 1/5/0",
                     hif.MemTimeout, hif.StallCount, hif.FlushCount);
        else pass_cnt++;

        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hif.MemReqM = 1; hif.MemReadyM = (i == 4);
            #1;
            if (i == 4) begin
                tot_cnt++;
                if (ctl() !== 7'b0)
                    $display("FAIL to_ready_ctl got %b exp %b", ctl(), 7'b0);
                else pass_cnt++;
            end
        end
        @(negedge clk);
        hif.MemReqM = 0; hif.MemReadyM = 0; hif.PCSrcE = 1;
        #1;
        tot_cnt++;
        if (hif.MemTimeout !== 1'b0 || ctl() !== 7'b0000110 || hif.StallCount !== 4'd4)
            $display("FAIL to_ready_run got %b/%b/%0d exp 0/%b/4",
                     hif.MemTimeout, ctl(), hif.StallCount, 7'b0000110);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        repeat (3) begin
            @(negedge clk);
            hif.MemReqM = 1; hif.MemReadyM = 0; hif.PCSrcE = 1;
            hif.RegWriteM = 1; hif.RdM = 5; hif.Rs1E = 5;
        end
        #1;
        reset = 1'b1;
        #1;
        tot_cnt++;
        if (ctl() !== 7'b0 || hif.ForwardAE !== 2'b00)
            $display("FAIL rmid_out got %b/%b exp 0/00", ctl(), hif.ForwardAE);
        else pass_cnt++;
        tot_cnt++;
        if (hif.StallCount !== 4'd0 || hif.MemTimeout !== 1'b0)
            $display("FAIL rmid_regs got %0d/%b exp 0/0", hif.StallCount, hif.MemTimeout);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        hif.MemReqM = 0;
        #1;
        tot_cnt++;
        if (ctl() !== 7'b0000110 || hif.ForwardAE !== 2'b10)
            $display("FAIL rmid_run got %b/%b exp %b/10", ctl(), hif.ForwardAE, 7'b0000110);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (20) begin
            @(negedge clk);
            hif.ResultSrcE = 2'b01; hif.RdE = 4; hif.Rs1D = 4;
        end
        @(negedge clk);
        idle();
        #1;
        tot_cnt++;
        if (hif.StallCount !== 4'd15 || hif.FlushCount !== 4'd15)
            $display("FAIL sat got %0d/%0d exp 15/15", hif.StallCount, hif.FlushCount);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
